// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: valid/ready burst master for a single-port RAM with a
// combinational read path, registered write commit and shared tri-state data bus.
module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  capture;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign mem_wr_en = (state == WRITE) && wr_valid;
  assign mem_addr  = addr_q;
  assign mem_data  = mem_wr_en ? wr_data : {DATA_WIDTH{1'bz}};

  // A read beat is taken only when the output register is empty or being drained.
  assign capture = (state == READ) && (!rd_valid || rd_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (capture) begin
        rd_data  <= mem_data;
        rd_valid <= 1'b1;
        rd_last  <= (cnt_q == '0);
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            state  <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + 1'b1;
            if (cnt_q == '0) state <= TURN;
            else             cnt_q <= cnt_q - 1'b1;
          end
        end
        READ: begin
          if (capture) begin
            addr_q <= addr_q + 1'b1;
            if (cnt_q == '0) state <= IDLE;
            else             cnt_q <= cnt_q - 1'b1;
          end
        end
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: drives ram_port_ctrl against a behavioural RAM and
// checks every burst against a reference memory image and expected-beat queue.
module tb_ram_port_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          cmd_ready, wr_ready, rd_valid, rd_last, busy, mem_wr_en;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            commits = 0;
  int            checks  = 0;
  int            passed  = 0;

  ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: drives the bus whenever it is not being written.
  assign mem_data = mem_wr_en ? {DW{1'bz}} : ram[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_data;
      commits       <= commits + 1;
    end
  end

  task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input int mode, input logic [DW-1:0] base);
    logic [AW-1:0] p;
    int beats, cyc, c0;
    logic wv;
    p = a; beats = 0; cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL wr_cmd_ready: got %b want 1", cmd_ready); else passed++;
    c0 = commits;
    while (beats <= int'(l) && cyc < 80) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0:       wv = 1'b1;
        1:       wv = (cyc % 2 == 0);
        default: wv = ($urandom_range(0, 3) != 0);
      endcase
      wr_valid = wv;
      wr_data  = (wv && base != '0) ? base + DW'(beats) : DW'($urandom);
      #1;
      checks++; if (mem_wr_en !== wv) $display("[TB] FAIL wr_en: got %b want %b", mem_wr_en, wv); else passed++;
      checks++; if (mem_addr !== p) $display("[TB] FAIL wr_addr: got %h want %h", mem_addr, p); else passed++;
      checks++; if (wr_ready !== 1'b1 || busy !== 1'b1)
        $display("[TB] FAIL wr_state: got wr_ready=%b busy=%b want 1/1", wr_ready, busy); else passed++;
      if (wv) begin
        checks++; if (mem_data !== wr_data) $display("[TB] FAIL wr_bus: got %h want %h", mem_data, wr_data); else passed++;
        ref_mem[p] = wr_data;
        p++;
        beats++;
      end else begin
        checks++; if (mem_data !== ram[mem_addr]) $display("[TB] FAIL wr_gap_bus: got %h want %h", mem_data, ram[mem_addr]); else passed++;
      end
      cyc++;
    end
    checks++; if (beats <= int'(l)) $display("[TB] FAIL wr_timeout: got %0d beats want %0d", beats, int'(l) + 1); else passed++;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = $urandom;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0)
      $display("[TB] FAIL turn: got wr_en=%b cmd_ready=%b busy=%b wr_ready=%b want 0/0/1/0",
               mem_wr_en, cmd_ready, busy, wr_ready); else passed++;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL wr_idle: got cmd_ready=%b busy=%b want 1/0", cmd_ready, busy); else passed++;
    checks++; if (commits - c0 !== int'(l) + 1)
      $display("[TB] FAIL wr_commits: got %0d want %0d", commits - c0, int'(l) + 1); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (ram[i] !== ref_mem[i]) $display("[TB] FAIL ram[%0d]: got %h want %h", i, ram[i], ref_mem[i]); else passed++;
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode);
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] p;
    logic [6:0]    pat;
    int cyc;
    pat = 7'b1011001;
    p = a;
    for (int i = 0; i <= int'(l); i++) begin
      exp_q.push_back(ref_mem[p]);
      p++;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = $urandom;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rd_cmd_ready: got %b want 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; rd_ready = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL rd_latency: got rd_valid=%b busy=%b want 0/1", rd_valid, busy); else passed++;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 80) begin
      @(negedge clk);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = pat[cyc % 7];
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wr_data = $urandom;
      #1;
      checks++; if (rd_valid !== 1'b1) $display("[TB] FAIL rd_valid: got %b want 1", rd_valid); else passed++;
      checks++; if (rd_data !== exp_q[0]) $display("[TB] FAIL rd_data: got %h want %h", rd_data, exp_q[0]); else passed++;
      checks++; if (rd_last !== (exp_q.size() == 1)) $display("[TB] FAIL rd_last: got %b want %b", rd_last, exp_q.size() == 1); else passed++;
      checks++; if (mem_wr_en !== 1'b0 || mem_data !== ram[mem_addr])
        $display("[TB] FAIL rd_bus: got wr_en=%b data=%h want 0/%h", mem_wr_en, mem_data, ram[mem_addr]); else passed++;
      if (rd_ready) void'(exp_q.pop_front());
      cyc++;
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL rd_timeout: got %0d beats left want 0", exp_q.size()); else passed++;
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("[TB] FAIL rd_end: got rd_valid=%b busy=%b cmd_ready=%b want 0/0/1", rd_valid, busy, cmd_ready); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 ||
                    rd_last !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== '0)
        $display("[TB] FAIL reset_%0d: got cmd_ready=%b wr_ready=%b rd_valid=%b rd_data=%h rd_last=%b busy=%b wr_en=%b addr=%h want 1/0/0/0/0/0/0/0",
                 k, cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, mem_wr_en, mem_addr); else passed++;
      rst = 1'b0;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_write_burst();
    run_write(4'd3, 4'd2, 0, 32'hA0);
  endtask

  task automatic test_read_burst();
    run_read(4'd3, 4'd2, 0);
  endtask

  task automatic test_read_wrap();
    run_read(4'd14, 4'd3, 0);
  endtask

  task automatic test_read_stall();
    run_read(4'd14, 4'd3, 1);
  endtask

  task automatic test_write_gaps();
    run_write(AW'($urandom_range(0, DEPTH - 1)), 4'd2, 1, '0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    logic [DW-1:0] ea0, ea1, eb [3];
    a = 4'd5; b = 4'd15;
    ea0 = ref_mem[a]; a++; ea1 = ref_mem[a];
    for (int i = 0; i < 3; i++) begin eb[i] = ref_mem[b]; b++; end
    b = 4'd15;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; cmd_len = 4'd1; rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ea0 || rd_last !== 1'b0)
      $display("[TB] FAIL b2b_a0: got %b/%h/%b want 1/%h/0", rd_valid, rd_data, rd_last, ea0); else passed++;
    @(negedge clk);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = b; cmd_len = 4'd2;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ea1 || rd_last !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL b2b_pending: got %b/%h/%b ready=%b busy=%b want 1/%h/1 1 0",
               rd_valid, rd_data, rd_last, cmd_ready, busy, ea1); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ea1 || rd_last !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL b2b_hold: got %b/%h/%b busy=%b want 1/%h/1 1", rd_valid, rd_data, rd_last, busy, ea1); else passed++;
    @(negedge clk);
    rd_ready = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ea1)
      $display("[TB] FAIL b2b_drain: got %b/%h want 1/%h", rd_valid, rd_data, ea1); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (rd_valid !== 1'b1 || rd_data !== eb[i] || rd_last !== (i == 2))
        $display("[TB] FAIL b2b_b%0d: got %b/%h/%b want 1/%h/%b", i, rd_valid, rd_data, rd_last, eb[i], i == 2); else passed++;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL b2b_end: got rd_valid=%b busy=%b want 0/0", rd_valid, busy); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic [AW-1:0] a;
    logic [DW-1:0] e0, e1;
    a = AW'($urandom_range(0, DEPTH - 1));
    e0 = ref_mem[a]; a++; e1 = ref_mem[a]; a--;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 4'd3; rd_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== e0) $display("[TB] FAIL rst_beat0: got %b/%h want 1/%h", rd_valid, rd_data, e0); else passed++;
    @(negedge clk);
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== e1) $display("[TB] FAIL rst_beat1: got %b/%h want 1/%h", rd_valid, rd_data, e1); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || cmd_ready !== 1'b1 || rd_data !== '0)
      $display("[TB] FAIL rst_mid: got rd_valid=%b busy=%b addr=%h cmd_ready=%b rd_data=%h want 0/0/0/1/0",
               rd_valid, busy, mem_addr, cmd_ready, rd_data); else passed++;
    run_write(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(0, 5)), 0, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(0, 15)), 2, '0);
      else
        run_read(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(0, 15)), 2);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    run_write('0, 4'd15, 0, '0);
    test_write_burst();
    test_read_burst();
    test_read_wrap();
    test_read_stall();
    test_write_gaps();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Bus-side master for the single-port RAM. It accepts read and write burst commands on a valid/ready interface and converts them into the RAM's `wr_en`/`addr`/bidirectional `data` signalling. It owns the tri-state `data` bus and returns read beats on a back-pressurable stream. The block sits between the system datapath and one RAM instance; the RAM's read path is combinational and its write commits on the rising edge of `clk` while `wr_en` is high.

## Interface
- `ADDR_WIDTH`, 4, RAM address width; the address counter wraps modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32, data width of the RAM word and of both streams.
- `LEN_WIDTH`, 4, width of `cmd_len`; a burst is `cmd_len`+1 beats, from 1 to 2^LEN_WIDTH.
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 selects a write burst, 0 selects a read burst.
- `cmd_addr`  in  ADDR_WIDTH  start address of the burst.
- `cmd_len`  in  LEN_WIDTH  number of beats minus 1.
- `wr_valid`  in  1  write beat offered.
- `wr_ready`  out  1  write beat accepted on `wr_valid && wr_ready`.
- `wr_data`  in  DATA_WIDTH  write beat payload.
- `rd_valid`  out  1  read beat available.
- `rd_ready`  in  1  read beat consumed on `rd_valid && rd_ready`.
- `rd_data`  out  DATA_WIDTH  read beat payload, registered.
- `rd_last`  out  1  marks the final beat of a read burst; valid only while `rd_valid` is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `mem_wr_en`  out  1  drives the RAM's `wr_en`.
- `mem_addr`  out  ADDR_WIDTH  drives the RAM's `addr`; comes from a register.
- `mem_data`  inout  DATA_WIDTH  RAM data bus.
  - Driven with `wr_data` only while `mem_wr_en` is 1.
  - High-impedance otherwise.

## Operation
- The FSM has four states: IDLE, WRITE, READ and TURN.
- Internal registers:
  - `addr_q`: address counter, drives `mem_addr`.
  - `cnt_q`: beats remaining minus 1.
- **IDLE**
  - `cmd_ready` = 1.
  - On handshake, load `addr_q` ← `cmd_addr` and `cnt_q` ← `cmd_len`.
  - Go to WRITE if `cmd_write` is 1, otherwise to READ.
- **WRITE**
  - `wr_ready` = 1.
  - `mem_wr_en` = `wr_valid`, combinationally. `mem_data` = `wr_data` in the same cycle.
  - On each accepted beat:
    - Increment `addr_q`, wrapping.
    - If `cnt_q` = 0, go to TURN; otherwise decrement `cnt_q`.
  - When `wr_valid` is 0, the FSM stalls with no side effects and the bus is released.
- **TURN**
  - Exactly one cycle with `mem_wr_en` = 0, bus released and `cmd_ready` = 0.
  - Then go to IDLE.
  - TURN guarantees a bus-release cycle after any write before the next command can start.
- **READ**
  - `mem_wr_en` = 0 and the bus is released, so the RAM drives `mem_data` = mem[`addr_q`].
  - Capture condition: a cycle where `!rd_valid || rd_ready`. In such a cycle:
    - `rd_data` ← `mem_data`, `rd_valid` ← 1, `rd_last` ← (`cnt_q` = 0).
    - Increment `addr_q`.
    - If `cnt_q` = 0, go to IDLE; otherwise decrement `cnt_q`.
  - While `rd_valid && !rd_ready`, the FSM holds `addr_q`, `cnt_q` and the output register.
- **Output register outside READ:** `rd_valid` clears on `rd_ready` if no new capture happens in that cycle.
- **Read after read:**
  - A new command may be accepted in IDLE while the last read beat is still pending.
  - The first beat of the new burst obeys the capture rule, so no beat is ever dropped or overwritten.
- **Address wrap:** `addr_q` = 2^ADDR_WIDTH−1 increments to 0; bursts that cross the top of memory are legal.
- **Reset** (including mid-burst):
  - FSM → IDLE, `addr_q` = 0, `cnt_q` = 0.
  - The remaining beats of the burst are discarded.
- **Values while `rst` = 1 and on the first cycle after it deasserts:**
  - `cmd_ready` = 1 (state is IDLE).
  - `wr_ready` = 0, `rd_valid` = 0, `rd_data` = 0, `rd_last` = 0, `busy` = 0.
  - `mem_wr_en` = 0, `mem_addr` = 0, `mem_data` = Z.

## Timing
- **Write:** a beat accepted at edge N is committed to the RAM at edge N.
  - Earliest first write: the cycle after the command handshake.
  - Throughput: 1 beat/cycle.
- **Write command occupancy:** (`cmd_len`+1) cycles with no stalls, plus 1 TURN cycle.
  - The next command can be accepted no earlier than 2 cycles after the final write beat.
- **Read:** command handshake at edge N → READ during cycle N+1 → first `rd_valid` after edge N+1.
  - Latency from command to first beat: 1 cycle.
  - Throughput: 1 beat/cycle while `rd_ready` = 1.
- **Read payload:** `rd_data` is stable from the capture edge until the edge at which the beat is consumed.
- **Protocol rules:**
  - `cmd_ready`, `wr_ready` and `mem_wr_en` depend on the FSM state and, for `mem_wr_en`, on `wr_valid`.
  - Outputs do not depend combinationally on `rd_ready`, except for internal stall gating.
  - `busy` rises on the cycle after the command handshake and falls on the cycle after WRITE/TURN/READ exits.

## Test plan
- Reset, then write `cmd_addr`=3, `cmd_len`=2, data A0/A1/A2, with `wr_valid` held high.
  - RAM[3..5] = A0, A1, A2.
  - `mem_wr_en` is high for exactly 3 cycles, followed by 1 TURN cycle with `cmd_ready` = 0.
- Read `cmd_addr`=3, `cmd_len`=2, with `rd_ready` = 1.
  - `rd_valid` rises 1 cycle after the handshake.
  - Beats A0, A1, A2 arrive on consecutive cycles; `rd_last` is high only on A2.
  - `mem_data` is never driven by the controller during the read.
- Read `cmd_addr`=14, `cmd_len`=3 (ADDR_WIDTH=4) → addresses 14, 15, 0, 1 in order.
- Same read with `rd_ready` toggling 1,0,0,1,1,0,1: every beat is delivered exactly once, in order, and `rd_data` stays stable while stalled.
- Write burst with `wr_valid` gaps (1,0,1,0,1) → only 3 commits, `mem_data` = Z on the gap cycles, and correct RAM contents.
- Assert `rst` on the 2nd beat of a 4-beat read.
  - The next cycle shows IDLE, `rd_valid` = 0, `busy` = 0, `mem_addr` = 0.
  - A new write command is then accepted normally.
